// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard unit. Tracks in-flight destinations, produces
//               registered forwarding selects, load-use stall, redirect squash.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_READY = 2,
    parameter int KILL_SLOTS = 1,
    parameter int AW         = 5,
    localparam int SW        = $clog2(FWD_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  id_valid,
    input  logic [NUM_SRC*AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]    id_rs_used,
    input  logic [AW-1:0]         id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  redirect,
    output logic                  stall,
    output logic                  issue_kill,
    output logic [NUM_SRC*SW-1:0] fwd_sel,
    output logic                  x_valid
);

    if (NUM_SRC < 1) begin : g_bad_num_src
        $fatal(1, "hazard_ctrl: NUM_SRC must be >= 1");
    end
    if (FWD_STAGES < 1 || FWD_STAGES > 6) begin : g_bad_fwd_stages
        $fatal(1, "hazard_ctrl: FWD_STAGES must be 1..6");
    end
    if (LOAD_READY < 2 || LOAD_READY > FWD_STAGES + 1) begin : g_bad_load_ready
        $fatal(1, "hazard_ctrl: LOAD_READY must be 2..FWD_STAGES+1");
    end
    if (KILL_SLOTS < 0 || KILL_SLOTS > 7) begin : g_bad_kill_slots
        $fatal(1, "hazard_ctrl: KILL_SLOTS must be 0..7");
    end
    if (AW < 1) begin : g_bad_aw
        $fatal(1, "hazard_ctrl: AW must be >= 1");
    end

    localparam logic [SW-1:0] c_last   = SW'(FWD_STAGES);
    localparam logic [SW-1:0] c_ld_lim = SW'(LOAD_READY - 1);
    localparam logic [2:0]    c_kill   = 3'(KILL_SLOTS);

    logic [FWD_STAGES:1]   r_v;
    logic [FWD_STAGES:1]   r_we;
    logic [FWD_STAGES:1]   r_ld;
    logic [AW-1:0]         r_rd [1:FWD_STAGES];
    logic [2:0]            r_kc;
    logic [NUM_SRC*SW-1:0] r_fwd;
    logic                  r_xv;

    logic [SW-1:0]         w_yk [NUM_SRC];
    logic [NUM_SRC-1:0]    w_yld;
    logic [NUM_SRC*SW-1:0] w_sel;
    logic                  w_ld_hit;
    logic                  w_issue;

    // Scan oldest to youngest so the smallest matching stage is left standing.
    always_comb begin
        w_sel    = '0;
        w_ld_hit = 1'b0;
        w_yld    = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            w_yk[j] = '0;
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (id_rs_used[j] && (id_rs[j*AW +: AW] != '0) && r_v[k] && r_we[k] &&
                    (r_rd[k] == id_rs[j*AW +: AW])) begin
                    w_yk[j]  = SW'(k);
                    w_yld[j] = r_ld[k];
                end
            end
            // The producer moves one stage on by the time the consumer is in X;
            // leaving the last tracked stage means the regfile already has it.
            if ((w_yk[j] != '0) && (w_yk[j] < c_last)) begin
                w_sel[j*SW +: SW] = w_yk[j] + 1'b1;
            end
            if (w_yld[j] && (w_yk[j] < c_ld_lim)) begin
                w_ld_hit = 1'b1;
            end
        end
    end

    assign issue_kill = redirect | (r_kc != 3'd0);
    assign stall      = id_valid & ~issue_kill & w_ld_hit;
    assign w_issue    = id_valid & ~stall & ~issue_kill;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v   <= '0;
            r_we  <= '0;
            r_ld  <= '0;
            for (int k = 1; k <= FWD_STAGES; k++) begin
                r_rd[k] <= '0;
            end
            r_kc  <= 3'd0;
            r_fwd <= '0;
            r_xv  <= 1'b0;
        end else if (!hold) begin
            r_v[1]  <= w_issue;
            r_we[1] <= w_issue & id_we;
            r_ld[1] <= w_issue & id_is_load;
            r_rd[1] <= w_issue ? id_rd : '0;
            for (int k = 2; k <= FWD_STAGES; k++) begin
                r_v[k]  <= r_v[k-1];
                r_we[k] <= r_we[k-1];
                r_ld[k] <= r_ld[k-1];
                r_rd[k] <= r_rd[k-1];
            end
            r_fwd <= w_issue ? w_sel : '0;
            r_xv  <= w_issue;
            if (redirect) begin
                r_kc <= c_kill;
            end else if (r_kc != 3'd0) begin
                r_kc <= r_kc - 3'd1;
            end
        end
    end

    assign fwd_sel = r_fwd;
    assign x_valid = r_xv;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl with a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    localparam int NUM_SRC    = 2;
    localparam int FWD_STAGES = 3;
    localparam int LOAD_READY = 3;
    localparam int KILL_SLOTS = 2;
    localparam int AW         = 5;
    localparam int SW         = $clog2(FWD_STAGES + 1);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  hold;
    logic                  id_valid;
    logic [NUM_SRC*AW-1:0] id_rs;
    logic [NUM_SRC-1:0]    id_rs_used;
    logic [AW-1:0]         id_rd;
    logic                  id_we;
    logic                  id_is_load;
    logic                  redirect;
    logic                  stall;
    logic                  issue_kill;
    logic [NUM_SRC*SW-1:0] fwd_sel;
    logic                  x_valid;

    hazard_ctrl #(
        .NUM_SRC   (NUM_SRC),
        .FWD_STAGES(FWD_STAGES),
        .LOAD_READY(LOAD_READY),
        .KILL_SLOTS(KILL_SLOTS),
        .AW        (AW)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rs_used(id_rs_used),
        .id_rd     (id_rd),
        .id_we     (id_we),
        .id_is_load(id_is_load),
        .redirect  (redirect),
        .stall     (stall),
        .issue_kill(issue_kill),
        .fwd_sel   (fwd_sel),
        .x_valid   (x_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic          we;
        logic          ld;
        logic [AW-1:0] rd;
    } ent_t;

    typedef struct packed {
        logic                  xv;
        logic [NUM_SRC*SW-1:0] fwd;
    } rec_t;

    // In-flight history, index 0 = most recently issued slot (X).
    ent_t pipe[$];
    rec_t exp_q[$];
    rec_t last_rec;
    int   kc;
    int   total;
    int   bad;
    bit   mon_en;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic v, input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                        input logic [1:0] used, input logic [AW-1:0] rd, input logic we,
                        input logic ld, input logic redir, input logic hld, input logic rstn);
        logic [AW-1:0]         rs;
        int                    yk;
        logic                  yl;
        logic                  any_ld;
        logic                  e_kill;
        logic                  e_stall;
        logic                  issue;
        logic [NUM_SRC*SW-1:0] sel;
        ent_t                  ne;
        @(negedge clk);
        id_valid   = v;
        id_rs      = {rs1, rs0};
        id_rs_used = used;
        id_rd      = rd;
        id_we      = we;
        id_is_load = ld;
        redirect   = redir;
        hold       = hld;
        reset      = rstn;
        mon_en     = 1'b1;
        #1;
        e_kill = redir || (kc != 0);
        any_ld = 1'b0;
        sel    = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            rs = (j == 0) ? rs0 : rs1;
            yk = 0;
            yl = 1'b0;
            if (used[j] && rs != '0) begin
                for (int i = 0; i < pipe.size(); i++) begin
                    if (pipe[i].v && pipe[i].we && pipe[i].rd == rs) begin
                        yk = i + 1;
                        yl = pipe[i].ld;
                        break;
                    end
                end
            end
            if (yk != 0 && yk < FWD_STAGES) sel[j*SW +: SW] = SW'(yk + 1);
            if (yk != 0 && yl && (yk + 1) < LOAD_READY) any_ld = 1'b1;
        end
        e_stall = v && !e_kill && any_ld;
        check("issue_kill", int'(issue_kill), int'(e_kill));
        check("stall", int'(stall), int'(e_stall));
        if (!rstn) begin
            for (int i = 0; i < FWD_STAGES; i++) pipe[i] = '0;
            kc = 0;
            exp_q.push_back('0);
        end else if (!hld) begin
            issue = v && !e_stall && !e_kill;
            ne    = '0;
            if (issue) begin
                ne.v  = 1'b1;
                ne.we = we;
                ne.ld = ld;
                ne.rd = rd;
            end
            pipe.push_front(ne);
            void'(pipe.pop_back());
            if (redir) kc = KILL_SLOTS;
            else if (kc != 0) kc = kc - 1;
            exp_q.push_back({issue, issue ? sel : {NUM_SRC*SW{1'b0}}});
        end
    endtask

    task automatic op(input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                      input logic [1:0] used, input logic [AW-1:0] rd, input logic ld);
        step(1'b1, rs0, rs1, used, rd, 1'b1, ld, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic nop();
        step(1'b0, '0, '0, 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: one expected record per non-held edge; held edges must repeat.
    initial begin
        logic h;
        logic r;
        rec_t rec;
        forever begin
            @(posedge clk);
            h = hold;
            r = reset;
            #1;
            if (mon_en) begin
                if (!r || !h) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL scoreboard_underflow actual=empty required=record @%0t", $time);
                    end else begin
                        rec = exp_q.pop_front();
                        check("x_valid", int'(x_valid), int'(rec.xv));
                        check("fwd_sel", int'(fwd_sel), int'(rec.fwd));
                        last_rec = rec;
                    end
                end else begin
                    check("x_valid_held", int'(x_valid), int'(last_rec.xv));
                    check("fwd_sel_held", int'(fwd_sel), int'(last_rec.fwd));
                end
            end
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        kc         = 0;
        mon_en     = 1'b0;
        last_rec   = '0;
        reset      = 1'b0;
        hold       = 1'b0;
        id_valid   = 1'b0;
        id_rs      = '0;
        id_rs_used = '0;
        id_rd      = '0;
        id_we      = 1'b0;
        id_is_load = 1'b0;
        redirect   = 1'b0;
        for (int i = 0; i < FWD_STAGES; i++) pipe.push_back('0);

        step(1'b0, '0, '0, 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // back-to-back dependency
        op(5'd1, 5'd2, 2'b11, 5'd5, 1'b0);
        op(5'd5, 5'd5, 2'b11, 5'd6, 1'b0);
        nop(); nop(); nop();
        // one gap, x0 source
        op(5'd0, 5'd0, 2'b00, 5'd5, 1'b0);
        nop();
        op(5'd5, 5'd0, 2'b11, 5'd7, 1'b0);
        nop(); nop(); nop();
        // load-use: same decode presented until it issues
        op(5'd0, 5'd0, 2'b01, 5'd8, 1'b1);
        op(5'd8, 5'd1, 2'b11, 5'd9, 1'b0);
        op(5'd8, 5'd1, 2'b11, 5'd9, 1'b0);
        nop(); nop(); nop();
        // youngest producer wins
        op(5'd0, 5'd0, 2'b00, 5'd3, 1'b0);
        op(5'd0, 5'd0, 2'b00, 5'd3, 1'b0);
        op(5'd3, 5'd3, 2'b11, 5'd4, 1'b0);
        // redirect squash window
        step(1'b1, 5'd4, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        op(5'd4, 5'd0, 2'b01, 5'd11, 1'b0);
        op(5'd4, 5'd0, 2'b01, 5'd12, 1'b0);
        op(5'd4, 5'd0, 2'b01, 5'd13, 1'b0);
        // hold mid-stream, then reset with work in flight
        op(5'd0, 5'd0, 2'b00, 5'd5, 1'b0);
        op(5'd5, 5'd5, 2'b11, 5'd6, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd6, 5'd5, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        op(5'd6, 5'd5, 2'b11, 5'd7, 1'b0);
        op(5'd0, 5'd0, 2'b00, 5'd5, 1'b1);
        step(1'b1, 5'd5, 5'd5, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        op(5'd5, 5'd5, 2'b11, 5'd5, 1'b0);
        nop(); nop();

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 8,
                 AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) >= 2);
        end

        @(posedge clk);
        #3;
        check("scoreboard_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
